// File: rtl/smem_req_sequencer.sv
// Core-side request sequencer: in-order request FIFO feeding one outstanding bank transaction.
// Optional watchdog on the WAIT state is enabled by defining SMEM_TIMEOUT_EN.
module smem_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_finish,
  output logic        busy,
  output logic [4:0]  q_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("smem_req_sequencer: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [20:0]     fifo_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [4:0]      count_r;
  logic            issue_we_r;
  logic [11:0]     issue_addr_r;
  logic [7:0]      issue_wdata_r;
  logic            push_s;
  logic            pop_s;

  assign req_ready = (count_r != 5'(DEPTH));
  assign q_count   = count_r;
  assign busy      = (state_r != IDLE) || (count_r != 5'd0);
  assign push_s    = req_valid && req_ready;
  assign pop_s     = (state_r == IDLE) && (count_r != 5'd0);

`ifdef SMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt_r;
  logic          resp_err_r;
  assign resp_err = resp_err_r;
`else
  assign resp_err = 1'b0;
`endif

  // FIFO payload storage; contents are don't-care while the slot is empty
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {req_we, req_addr, req_wdata};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 5'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transaction FSM with registered lane and response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      issue_we_r    <= 1'b0;
      issue_addr_r  <= 12'd0;
      issue_wdata_r <= 8'd0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= 12'd0;
      mem_wdata     <= 8'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 8'd0;
`ifdef SMEM_TIMEOUT_EN
      wd_cnt_r      <= '0;
      resp_err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            {issue_we_r, issue_addr_r, issue_wdata_r} <= fifo_mem_r[rd_ptr_r];
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          mem_addr  <= issue_addr_r;
          mem_wdata <= issue_wdata_r;
          mem_read  <= !issue_we_r;
          mem_write <= issue_we_r;
`ifdef SMEM_TIMEOUT_EN
          wd_cnt_r  <= '0;
`endif
          state_r   <= WAIT;
        end
        WAIT: begin
          // finish wins over a watchdog expiry in the same cycle
          if (mem_finish) begin
            resp_rdata <= issue_we_r ? 8'd0 : mem_rdata;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
`ifdef SMEM_TIMEOUT_EN
            resp_err_r <= 1'b0;
`endif
            state_r    <= RESP;
          end
`ifdef SMEM_TIMEOUT_EN
          else if (wd_cnt_r == TW'(TIMEOUT - 1)) begin
            resp_rdata <= 8'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err_r <= 1'b1;
            state_r    <= RESP;
          end else begin
            wd_cnt_r   <= wd_cnt_r + TW'(1);
          end
`endif
        end
        RESP: begin
          resp_valid <= 1'b0;
`ifdef SMEM_TIMEOUT_EN
          resp_err_r <= 1'b0;
`endif
          state_r    <= IDLE;
        end
        default: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smem_req_sequencer.sv
// Randomized bench for smem_req_sequencer: transaction-level scoreboard plus a bank responder model.
// Exercises the SMEM_TIMEOUT_EN watchdog paths when that macro is defined.
module tb_smem_req_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [11:0] req_addr   = 12'd0;
  logic [7:0]  req_wdata  = 8'd0;
  logic [7:0]  mem_rdata  = 8'd0;
  logic        mem_finish = 1'b0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write, busy;
  logic [7:0]  resp_rdata, mem_wdata;
  logic [11:0] mem_addr;
  logic [4:0]  q_count;

  smem_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_finish(mem_finish),
    .busy(busy), .q_count(q_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic we; logic [11:0] addr; logic [7:0] wdata; logic [7:0] rdata; } txn_t;
  typedef struct { logic [7:0] rdata; logic err; int cyc; int rise; } rsp_t;

  txn_t       exp_q[$];
  rsp_t       rsp_log[$];
  logic [7:0] ref_mem  [4096];
  logic [7:0] bank_mem [4096];

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, acc_cnt = 0, acc_prev = 0, rise_cnt = 0, acc_cyc = 0;
  int   cur_rise = 0, wait_n = 0, lat = 0, force_lat = -1, a0 = 0;
`ifdef SMEM_TIMEOUT_EN
  int   wr_lat_max = TIMEOUT - 1, rd_lat_max = TIMEOUT + 1;
`else
  int   wr_lat_max = 4, rd_lat_max = 4;
`endif
  bit   hold_off = 0, spur_en = 0, out_active = 0, resp_due = 0, resp_to = 0, took = 0;
  logic lanes_prev = 1'b0, busy_prev = 1'b0, resp_prev = 1'b0;
  logic [4:0] q_prev = 5'd0;
  logic [7:0] cur_wd_seen = 8'd0;
  txn_t cur;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle observer and bank responder; runs 1 time unit after each rising edge
  task automatic monitor();
    logic lanes;
    bit   rise;
    txn_t head;
    rsp_t r;
    lanes      = mem_read | mem_write;
    mem_finish = 1'b0;
    mem_rdata  = 8'($urandom);
    if (!reset) begin
      check_eq("reset_state",
               {mem_read, mem_write, resp_valid, resp_err, busy, req_ready, q_count, mem_addr, mem_wdata, resp_rdata},
               {5'b00000, 1'b1, 5'd0, 12'd0, 8'd0, 8'd0});
      exp_q.delete();
      out_active = 0; resp_due = 0; acc_cnt = 0; rise_cnt = 0;
      ref_mem    = bank_mem;
      lanes_prev = 1'b0; q_prev = 5'd0; busy_prev = 1'b0; resp_prev = 1'b0; acc_prev = 0;
      return;
    end
    rise = lanes && !lanes_prev;
    check_eq("lane_excl", mem_read & mem_write, 1'b0);
    check_eq("ready_decode", req_ready, q_count != 5'(DEPTH));
    // a pop happens exactly one cycle before its lanes rise
    check_eq("q_count", q_prev, acc_prev - (rise_cnt + int'(rise)));
    check_eq("busy", busy_prev, (q_prev != 5'd0) || lanes_prev || resp_prev || rise);

    if (resp_due) begin
      check_eq("resp_valid", resp_valid, 1'b1);
      check_eq("lanes_drop", lanes, 1'b0);
      check_eq("resp_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        check_eq("resp_rdata", resp_rdata, resp_to ? 8'd0 : head.rdata);
        check_eq("resp_err", resp_err, resp_to);
      end
      r.rdata = resp_rdata; r.err = resp_err; r.cyc = cyc; r.rise = cur_rise;
      rsp_log.push_back(r);
      resp_due = 0;
    end else begin
      check_eq("resp_quiet", resp_valid, 1'b0);
    end

    if (rise) begin
      rise_cnt++;
      check_eq("issue_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        cur = exp_q[0];
        check_eq("issue_rw", {mem_write, mem_read}, {cur.we, !cur.we});
        check_eq("issue_addr", mem_addr, cur.addr);
        if (cur.we) check_eq("issue_wdata", mem_wdata, cur.wdata);
        cur_wd_seen = mem_wdata;
        cur_rise    = cyc;
        out_active  = 1;
        wait_n      = 0;
        lat = $urandom_range(0, cur.we ? wr_lat_max : rd_lat_max);
        if (force_lat >= 0) begin lat = force_lat; force_lat = -1; end
      end
    end else if (out_active) begin
      check_eq("lane_hold", {mem_write, mem_read, mem_addr, mem_wdata},
               {cur.we, !cur.we, cur.addr, cur_wd_seen});
    end

    if (out_active) begin
      if (!hold_off && wait_n >= lat) begin
        mem_finish = 1'b1;
        if (cur.we) bank_mem[cur.addr] = cur.wdata;
        else        mem_rdata = bank_mem[cur.addr];
        resp_due = 1; resp_to = 0; out_active = 0;
      end
`ifdef SMEM_TIMEOUT_EN
      else if (wait_n == TIMEOUT - 1) begin
        resp_due = 1; resp_to = 1; out_active = 0;
      end
`endif
      wait_n++;
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_finish = 1'b1;
    end
    lanes_prev = lanes; q_prev = q_count; busy_prev = busy; resp_prev = resp_valid; acc_prev = acc_cnt;
  endtask

  task automatic tick();
    bit   acc;
    txn_t t;
    acc     = reset && req_valid && req_ready;
    t.we    = req_we; t.addr = req_addr; t.wdata = req_wdata; t.rdata = 8'd0;
    @(posedge clock);
    cyc++;
    if (acc) begin
      if (t.we) ref_mem[t.addr] = t.wdata;
      else      t.rdata = ref_mem[t.addr];
      exp_q.push_back(t);
      acc_cnt++;
      acc_cyc = cyc;
    end
    #1;
    monitor();
  endtask

  task automatic push(input logic we, input logic [11:0] a, input logic [7:0] d);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check_eq("push_accept", ok, 1'b1);
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || resp_due || busy) && i < 300) begin
      tick();
      i++;
    end
    check_eq("drain_done", i < 300, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin ref_mem[i] = 8'd0; bank_mem[i] = 8'd0; end
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // write then read back the same address
    rsp_log.delete();
    force_lat = 3;
    push(1'b1, 12'h310, 8'hA5);
    a0 = acc_cyc;
    drain();
    force_lat = 0;
    push(1'b0, 12'h310, 8'h00);
    drain();
    check_eq("wr_rd_resps", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check_eq("issue_latency", rsp_log[0].rise - a0, 2);
      check_eq("wr_resp_latency", rsp_log[0].cyc - rsp_log[0].rise, 4);
      check_eq("wr_resp", {rsp_log[0].err, rsp_log[0].rdata}, {1'b0, 8'h00});
      check_eq("raw_rdata", {rsp_log[1].err, rsp_log[1].rdata}, {1'b0, 8'hA5});
      check_eq("rd_resp_latency", rsp_log[1].cyc - rsp_log[1].rise, 1);
    end

    // fill the FIFO while the head transaction is held in WAIT
    rsp_log.delete();
    hold_off = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(1'b0, {4'(i), 8'h10}, 8'h00);
      if (i == 3) check_eq("fill_q3", {mem_read, q_count}, {1'b1, 5'd3});
    end
    check_eq("full_state", {req_ready, q_count}, {1'b0, 5'(DEPTH)});
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h0F0; req_wdata = 8'h11;
    repeat (3) begin
      tick();
      check_eq("full_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    hold_off  = 0;
    drain();
    check_eq("fill_resps", rsp_log.size(), DEPTH + 1);
    if (rsp_log.size() == DEPTH + 1 && !rsp_log[3].err) check_eq("fill_order", rsp_log[3].rdata, 8'hA5);

    // finish pulse while idle is ignored
    tick();
    mem_finish = 1'b1; mem_rdata = 8'h5A;
    tick();
    check_eq("idle_finish", {busy, resp_valid, mem_read, mem_write, q_count}, 9'd0);
    tick();
    check_eq("idle_finish_after", resp_valid, 1'b0);

    // asynchronous reset in the middle of WAIT
    hold_off = 1;
    push(1'b0, 12'h310, 8'h00);
    push(1'b0, 12'h020, 8'h00);
    for (int i = 0; i < 20 && !out_active; i++) tick();
    repeat (2) tick();
    check_eq("pre_reset_wait", {mem_read, q_count}, {1'b1, 5'd1});
    #2 reset = 1'b0;
    #1;
    check_eq("reset_async", {mem_read, mem_write, busy, resp_valid, req_ready, q_count},
             {4'b0000, 1'b1, 5'd0});
    hold_off = 0;
    repeat (2) tick();
    reset = 1'b1;
    rsp_log.delete();
    repeat (8) tick();
    check_eq("no_resp_after_reset", rsp_log.size(), 0);

    // randomized traffic over a small address set, spurious finishes allowed
    spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      if (!req_valid && $urandom_range(0, 2) == 0) begin
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
        req_wdata = 8'($urandom);
      end
      took = req_valid && req_ready;
      tick();
      if (took) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    spur_en   = 0;
    drain();

`ifdef SMEM_TIMEOUT_EN
    // watchdog expiry, then the queued request proceeds normally
    rsp_log.delete();
    rd_lat_max = 3;
    force_lat  = 1000;
    push(1'b0, 12'h310, 8'h00);
    push(1'b0, 12'h310, 8'h00);
    drain();
    check_eq("to_resps", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      check_eq("to_err", {rsp_log[0].err, rsp_log[0].rdata}, {1'b1, 8'h00});
      check_eq("to_latency", rsp_log[0].cyc - rsp_log[0].rise, TIMEOUT);
      check_eq("to_next", {rsp_log[1].err, rsp_log[1].rdata}, {1'b0, 8'hA5});
    end
    // finish on the last allowed WAIT cycle wins over the watchdog
    rsp_log.delete();
    force_lat = TIMEOUT - 1;
    push(1'b0, 12'h310, 8'h00);
    drain();
    check_eq("tie_resps", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check_eq("tie_ok", {rsp_log[0].err, rsp_log[0].rdata}, {1'b0, 8'hA5});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smem_req_sequencer.md
Name: smem_req_sequencer

Overview:
- Core-side request sequencer for the 16-bank shared memory, one instance per core slot.
- Buffers the core's 8-bit read/write requests in a small in-order FIFO.
- Drives that core's read/write/addr/data lanes into the bank arbiters with at most one transaction outstanding.
- Turns the arbiter's per-core finish pulse into a one-cycle response to the core.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, 2..16.
- TIMEOUT, 64: watchdog limit in cycles for an outstanding transaction; only used when SMEM_TIMEOUT_EN is defined.

Ports:
- clock, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: core presents a request.
- req_ready, out, 1: FIFO can accept; a request is taken when req_valid & req_ready are both high at a clock edge.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, 12: [11:8] bank number, [7:0] word in bank.
- req_wdata, in, 8: write data.
- resp_valid, out, 1: one-cycle response pulse.
- resp_rdata, out, 8: read data; 0 for writes.
- resp_err, out, 1: transaction timed out.
- mem_read, out, 1: read lane for this core.
- mem_write, out, 1: write lane for this core.
- mem_addr, out, 12: address lane.
- mem_wdata, out, 8: write-data lane.
- mem_rdata, in, 8: this core's byte of the bank data_out bus.
- mem_finish, in, 1: this core's bit of the bank finish bus.
- busy, out, 1: FSM not IDLE or FIFO non-empty.
- q_count, out, 5: current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset = 0), effective immediately without waiting for a clock edge:
  - FIFO emptied; FSM goes to IDLE.
  - mem_read, mem_write, resp_valid, resp_err, busy = 0.
  - mem_addr, mem_wdata, resp_rdata = 0; q_count = 0; req_ready = 1.
  - Reset asserted mid-transaction drops the lanes at once and discards the transaction with no response.
- FIFO:
  - req_ready = (q_count != DEPTH).
  - When full, req_ready stays 0 even in a cycle that pops; no bypass.
  - Push and pop in the same cycle leave q_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the issue registers (we, addr, wdata) and go to ISSUE.
  - ISSUE: drive mem_addr and mem_wdata; assert mem_read = !we or mem_write = we. Go to WAIT.
  - WAIT: hold the lanes stable. On mem_finish = 1:
    - capture mem_rdata (reads only; writes capture 0);
    - deassert mem_read/mem_write on the same edge;
    - go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle with resp_rdata, then go to IDLE.
- Lane rules:
  - mem_read and mem_write are never both 1.
  - The lanes are low for at least one cycle (the RESP cycle) between back-to-back transactions, so the arbiter sees the request drop.
- Latency:
  - Request accepted at edge 0 with the block idle and the FIFO empty: mem_read/mem_write are high from edge 2.
  - If mem_finish is first high in the cycle after edge k, resp_valid is high in the cycle after edge k+1.
  - Best-case round trip: 4 cycles plus bank latency.
- Ordering: strictly in order, one outstanding, so read-after-write to the same address returns the written data.
- mem_finish seen in IDLE, ISSUE or RESP is ignored.
- mem_rdata is sampled only in WAIT, in the cycle mem_finish = 1.
- All outputs are registered except req_ready, busy and q_count, which are decoded from registers.

Optional Feature:
- Macro: SMEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no mem_finish: deassert the lanes, go to RESP, and respond with resp_err = 1 and resp_rdata = 0.
  - mem_finish arriving in the same cycle as the limit wins; the response is normal with resp_err = 0.
- Undefined: no counter; resp_err is tied to 0; WAIT lasts indefinitely.

Test Plan:
- Reset, then write 0xA5 to addr 0x3_10; mem_finish pulses 3 cycles after mem_write rises → mem_write low after the finish edge; resp_valid for 1 cycle with resp_err = 0.
- Read addr 0x3_10 with mem_rdata = 0xA5 during the finish cycle → resp_rdata = 0xA5, and no gap violation between the two transactions (lanes low ≥ 1 cycle).
- Push DEPTH+1 requests back-to-back while mem_finish is held off → req_ready = 0 after 4 accepted; q_count = 3 while the first is in WAIT; responses come back in push order.
- Pulse mem_finish while in IDLE → no state change and no resp_valid.
- Drop reset low during WAIT → mem_read = 0 and q_count = 0 before the next edge; no response follows.
- With SMEM_TIMEOUT_EN and TIMEOUT = 8, never assert mem_finish → resp_valid with resp_err = 1 and resp_rdata = 0 after 8 WAIT cycles; then the next queued request issues.
